keypad_bcd_entry: RTL and testbench

Scans a 4x4 matrix keypad, debounces it, and assembles a 10-digit packed-BCD operand plus a 4-bit mode code. It is the input end of the display path: its BCD, mode and disp_en outputs drive the 12-digit seven-segment driver directly. A completed operand is handed to the RSA datapath through a valid/ready handshake.

---
 rtl/keypad_bcd_entry.sv | 262 ++++++++++++++++++++++++++
 tb/tb_keypad_bcd_entry.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_bcd_entry.sv
// 4x4 matrix keypad scanner with frame-level debounce, feeding a 10-digit packed-BCD
// entry register, a mode selector and a valid/ready operand handoff.
module keypad_bcd_entry #(
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 8,
  parameter int unsigned NUM_MODES       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [39:0] BCD,
  output logic [3:0]  mode,
  output logic        disp_en,
  output logic [3:0]  digit_cnt,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned    ScanW     = $clog2(SCAN_DIV);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
  localparam logic [4:0]     KeyNone   = 5'h10;
  localparam logic [7:0]     StableMax = 8'(DEBOUNCE_FRAMES);
  localparam logic [3:0]     ModeLast  = 4'(NUM_MODES - 1);
  localparam logic [3:0]     MaxDigits = 4'd10;

  typedef enum logic [2:0] {
    ActNop,
    ActDigit,
    ActBack,
    ActClear,
    ActMode,
    ActEnter
  } act_e;

  // Column synchronizer
  logic [3:0] col_meta_q, col_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
    end
  end

  // Row scan timing
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]       row_q, row_d;
  logic             slot_last;
  logic             frame_done;

  always_comb begin
    slot_last  = (scan_cnt_q == ScanLast);
    frame_done = slot_last && (row_q == 2'd3);
    scan_cnt_d = slot_last ? '0 : scan_cnt_q + ScanW'(1);
    row_d      = slot_last ? row_q + 2'd1 : row_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      row_q      <= 2'd0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      row_q      <= row_d;
    end
  end

  assign row_n = ~(4'b0001 << row_q);

  // Per-row column analysis on the sampling cycle
  logic [2:0] row_hits;
  logic [1:0] row_col;

  always_comb begin
    row_hits = 3'd0;
    row_col  = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_sync_q[c]) begin
        row_hits = row_hits + 3'd1;
        row_col  = 2'(c);
      end
    end
  end

  // Frame accumulation: hit count saturates at 2, which already means "ghost / reject"
  logic [1:0] hits_q, hits_d;
  logic [3:0] code_q, code_d;
  logic [2:0] hits_base, hits_sum;
  logic [4:0] frame_code;

  always_comb begin
    hits_base = (row_q == 2'd0) ? 3'd0 : {1'b0, hits_q};
    hits_sum  = hits_base + row_hits;
    hits_d    = hits_q;
    code_d    = code_q;
    if (slot_last) begin
      hits_d = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
      if (row_hits == 3'd1) begin
        code_d = {row_q, row_col};
      end
    end
    if (hits_sum == 3'd1) begin
      frame_code = {1'b0, (row_hits == 3'd1) ? {row_q, row_col} : code_q};
    end else begin
      frame_code = KeyNone;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q <= 2'd0;
      code_q <= 4'd0;
    end else begin
      hits_q <= hits_d;
      code_q <= code_d;
    end
  end

  // Debounce across whole frames
  logic [4:0] prev_q, prev_d;
  logic [7:0] stable_q, stable_d;
  logic [4:0] accepted_q, accepted_d;
  logic       key_evt_q, key_evt_d;
  logic [3:0] key_q, key_d;

  always_comb begin
    prev_d     = prev_q;
    stable_d   = stable_q;
    accepted_d = accepted_q;
    key_evt_d  = 1'b0;
    key_d      = key_q;
    if (frame_done) begin
      prev_d = frame_code;
      if (frame_code == prev_q) begin
        stable_d = (stable_q >= StableMax) ? StableMax : stable_q + 8'd1;
      end else begin
        stable_d = 8'd1;
      end
      if ((stable_d == StableMax) && (frame_code != accepted_q)) begin
        accepted_d = frame_code;
        if (frame_code != KeyNone) begin
          key_evt_d = 1'b1;
          key_d     = frame_code[3:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= KeyNone;
      stable_q   <= 8'd0;
      accepted_q <= KeyNone;
      key_evt_q  <= 1'b0;
      key_q      <= 4'd0;
    end else begin
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      accepted_q <= accepted_d;
      key_evt_q  <= key_evt_d;
      key_q      <= key_d;
    end
  end

  // Keymap: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  act_e       act;
  logic [3:0] act_digit;

  always_comb begin
    act       = ActNop;
    act_digit = 4'd0;
    case (key_q)
      4'd0:  begin act = ActDigit; act_digit = 4'd1; end
      4'd1:  begin act = ActDigit; act_digit = 4'd2; end
      4'd2:  begin act = ActDigit; act_digit = 4'd3; end
      4'd3:  act = ActClear;
      4'd4:  begin act = ActDigit; act_digit = 4'd4; end
      4'd5:  begin act = ActDigit; act_digit = 4'd5; end
      4'd6:  begin act = ActDigit; act_digit = 4'd6; end
      4'd7:  act = ActMode;
      4'd8:  begin act = ActDigit; act_digit = 4'd7; end
      4'd9:  begin act = ActDigit; act_digit = 4'd8; end
      4'd10: begin act = ActDigit; act_digit = 4'd9; end
      4'd12: act = ActBack;
      4'd13: begin act = ActDigit; act_digit = 4'd0; end
      4'd14: act = ActEnter;
      default: act = ActNop;
    endcase
  end

  // Entry register and handshake
  logic [39:0] bcd_q, bcd_d;
  logic [3:0]  mode_q, mode_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;

  always_comb begin
    bcd_d   = bcd_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (valid_q) begin
      // Operand is frozen while offered; key events are dropped
      if (out_ready) begin
        valid_d = 1'b0;
        bcd_d   = 40'd0;
        cnt_d   = 4'd0;
      end
    end else if (key_evt_q) begin
      case (act)
        ActDigit: begin
          if (cnt_q < MaxDigits) begin
            bcd_d = {bcd_q[35:0], act_digit};
            cnt_d = cnt_q + 4'd1;
          end
        end
        ActBack: begin
          if (cnt_q != 4'd0) begin
            bcd_d = {4'h0, bcd_q[39:4]};
            cnt_d = cnt_q - 4'd1;
          end
        end
        ActClear: begin
          bcd_d = 40'd0;
          cnt_d = 4'd0;
        end
        ActMode:  mode_d = (mode_q == ModeLast) ? 4'd0 : mode_q + 4'd1;
        ActEnter: begin
          if (cnt_q != 4'd0) begin
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q   <= 40'd0;
      mode_q  <= 4'd0;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      bcd_q   <= bcd_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign BCD       = bcd_q;
  assign mode      = mode_q;
  assign digit_cnt = cnt_q;
  assign out_valid = valid_q;
  assign disp_en   = (cnt_q != 4'd0);

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Keypad entry bench: a matrix model drives columns from the scanned rows; expected
// register states are queued at stimulus time and checked as the DUT updates.
module tb_keypad_bcd_entry;

  localparam int unsigned ScanDiv     = 8;
  localparam int unsigned Debounce    = 2;
  localparam int unsigned NumModes    = 4;
  localparam int          FrameCycles = 4 * ScanDiv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [39:0] bcd;
  logic [3:0]  mode;
  logic        disp_en;
  logic [3:0]  digit_cnt;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] pressed = 16'd0;

  always #5 clk = ~clk;

  keypad_bcd_entry #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_FRAMES(Debounce),
    .NUM_MODES      (NumModes)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_n    (col_n),
    .row_n    (row_n),
    .BCD      (bcd),
    .mode     (mode),
    .disp_en  (disp_en),
    .digit_cnt(digit_cnt),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // Passive switch matrix: a closed key pulls its column low while its row is driven
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  typedef struct packed {
    logic [39:0] bcd;
    logic [3:0]  mode;
    logic [3:0]  cnt;
    logic        valid;
    logic        disp;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  function automatic snap_t mk(logic [39:0] b, logic [3:0] m, logic [3:0] c, logic v);
    snap_t s;
    s.bcd   = b;
    s.mode  = m;
    s.cnt   = c;
    s.valid = v;
    s.disp  = (c != 4'd0);
    return s;
  endfunction

  function automatic snap_t observe();
    return mk(bcd, mode, digit_cnt, out_valid) | snap_t'({49'd0, disp_en}) &
           snap_t'({49'd0, 1'b1}) | (mk(bcd, mode, digit_cnt, out_valid) & ~snap_t'(1));
  endfunction

  function automatic int key_idx(byte ch);
    case (ch)
      "1": return 0;   "2": return 1;   "3": return 2;   "A": return 3;
      "4": return 4;   "5": return 5;   "6": return 6;   "B": return 7;
      "7": return 8;   "8": return 9;   "9": return 10;  "C": return 11;
      "*": return 12;  "0": return 13;  "#": return 14;  default: return 15;
    endcase
  endfunction

  task automatic push(logic [39:0] b, logic [3:0] m, logic [3:0] c, logic v);
    exp_q.push_back(mk(b, m, c, v));
  endtask

  task automatic check(string name, logic [39:0] act, logic [39:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Hold a key for the given number of frames, then release long enough to debounce NONE
  task automatic key(byte ch, int frames);
    pressed = 16'd1 << key_idx(ch);
    repeat (frames * FrameCycles) @(posedge clk);
    pressed = 16'd0;
    repeat (3 * FrameCycles) @(posedge clk);
  endtask

  task automatic drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20 * FrameCycles) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s: %0d expected updates outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every change of the visible entry state must match the next queued state
  initial begin
    snap_t last, cur, e;
    @(negedge rst);
    last = observe();
    forever begin
      @(negedge clk);
      cur = observe();
      if (cur !== last) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_update: got bcd=%h mode=%0d cnt=%0d valid=%b disp=%b, required no change",
                   cur.bcd, cur.mode, cur.cnt, cur.valid, cur.disp);
        end else begin
          e = exp_q.pop_front();
          if (cur === e) n_pass++;
          else $display("FAIL state_update: got bcd=%h mode=%0d cnt=%0d valid=%b disp=%b, required bcd=%h mode=%0d cnt=%0d valid=%b disp=%b",
                        cur.bcd, cur.mode, cur.cnt, cur.valid, cur.disp,
                        e.bcd, e.mode, e.cnt, e.valid, e.disp);
        end
        last = cur;
      end
    end
  end

  logic [39:0] tbl [10];
  logic [3:0]  mode_seq [5];
  string       digs;

  initial begin
    int n;
    tbl = '{40'h1, 40'h12, 40'h123, 40'h1234, 40'h12345, 40'h123456, 40'h1234567,
            40'h12345678, 40'h123456789, 40'h1234567890};
    mode_seq = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    digs = "1234567890";

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset mid-scan with non-trivial state
    push(40'h1, 4'd0, 4'd1, 1'b0);
    key("1", 3);
    push(40'h1, 4'd1, 4'd1, 1'b0);
    key("B", 3);
    drain("pre_reset");
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (row_n == 4'b1110 && n < 100);
    #2;
    push(40'h0, 4'd0, 4'd0, 1'b0);
    rst = 1'b1;
    #1;
    check("reset_row_n", 40'(row_n), 40'(4'b1110));
    check("reset_bcd", bcd, 40'h0);
    check("reset_mode", 40'(mode), 40'd0);
    check("reset_out_valid", 40'(out_valid), 40'd0);
    check("reset_digit_cnt", 40'(digit_cnt), 40'd0);
    check("reset_disp_en", 40'(disp_en), 40'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drain("reset");

    // Single update per press, long hold does not repeat
    push(40'h1, 4'd0, 4'd1, 1'b0);
    key("1", 3);
    push(40'h12, 4'd0, 4'd2, 1'b0);
    key("2", 3);
    check("two_digits_bcd", bcd, 40'h12);
    check("two_digits_disp_en", 40'(disp_en), 40'd1);
    push(40'h121, 4'd0, 4'd3, 1'b0);
    key("1", 10);
    push(40'h0, 4'd0, 4'd0, 1'b0);
    key("A", 3);
    drain("press_release");

    // Bounce: '5' flips every frame so no two consecutive frames agree
    repeat (8) begin
      pressed ^= 16'd1 << 5;
      repeat (FrameCycles) @(posedge clk);
    end
    pressed = 16'd0;
    repeat (3 * FrameCycles) @(posedge clk);
    push(40'h5, 4'd0, 4'd1, 1'b0);
    key("5", 3);
    pressed = (16'd1 << 5) | (16'd1 << 6);
    repeat (4 * FrameCycles) @(posedge clk);
    pressed = 16'd0;
    repeat (3 * FrameCycles) @(posedge clk);
    key("C", 3);
    key("D", 3);
    check("ghost_ignored_bcd", bcd, 40'h5);
    push(40'h0, 4'd0, 4'd0, 1'b0);
    key("A", 3);
    drain("bounce");

    // Ten digits fill the register; an eleventh is dropped
    for (int i = 0; i < 10; i++) begin
      push(tbl[i], 4'd0, 4'(i + 1), 1'b0);
      key(digs[i], 3);
    end
    key("7", 3);
    check("full_bcd", bcd, 40'h1234567890);
    push(40'h0123456789, 4'd0, 4'd9, 1'b0);
    key("*", 3);
    push(40'h0, 4'd0, 4'd0, 1'b0);
    key("A", 3);
    check("clear_disp_en", 40'(disp_en), 40'd0);
    drain("full_entry");

    // Mode wraps at NumModes
    for (int i = 0; i < 5; i++) begin
      push(40'h0, mode_seq[i], 4'd0, 1'b0);
      key("B", 3);
    end
    drain("mode_cycle");

    // Handshake: operand frozen while offered, cleared on acceptance
    push(40'h4, 4'd1, 4'd1, 1'b0);
    key("4", 3);
    push(40'h42, 4'd1, 4'd2, 1'b0);
    key("2", 3);
    push(40'h42, 4'd1, 4'd2, 1'b1);
    key("#", 3);
    key("7", 3);
    drain("enter");
    check("frozen_bcd", bcd, 40'h42);
    check("offered_valid", 40'(out_valid), 40'd1);
    push(40'h0, 4'd1, 4'd0, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    drain("accept");
    key("#", 3);
    key("*", 3);
    check("empty_enter_valid", 40'(out_valid), 40'd0);
    push(40'h5, 4'd1, 4'd1, 1'b0);
    key("5", 3);
    drain("after_handshake");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
